// File: rtl/gpio_pkg.sv
// Shared GPIO definitions: command opcodes, register map and initiator FSM states.
// Used by the bus initiator, the GPIO responder and the benches.
package gpio_pkg;

  typedef enum logic [2:0] {
    OP_REG_WR   = 3'd0,
    OP_REG_RD   = 3'd1,
    OP_PIN_SET  = 3'd2,
    OP_PIN_CLR  = 3'd3,
    OP_PIN_TGL  = 3'd4,
    OP_PIN_WAIT = 3'd5
  } gpio_op_e;

  localparam logic [7:0] GPIO_MODER = 8'h00;
  localparam logic [7:0] GPIO_IDR   = 8'h04;
  localparam logic [7:0] GPIO_ODR   = 8'h08;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_POLL = 3'd3,
    ST_RSP  = 3'd4
  } gpio_state_e;

endpackage

// File: rtl/gpio_bus_initiator.sv
// Turns single GPIO commands into MODER/IDR/ODR bus cycles and returns one response each.
// Pin ops are read-modify-write on ODR; PIN_WAIT polls IDR with a 16-bit timeout.
module gpio_bus_initiator
  import gpio_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [4:0]        cmd_pin,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              ce,
  output logic              wr_en,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  gpio_state_e       state_q, state_d;
  gpio_op_e          op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        pin_q, pin_d;
  logic [DATA_W-1:0] data_q, data_d;  // write data, or RMW shadow
  logic              lvl_q, lvl_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mask;
  logic              bus_act;

  assign mask = {{(DATA_W-1){1'b0}}, 1'b1} << pin_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_REG_WR;
      addr_q     <= '0;
      pin_q      <= '0;
      data_q     <= '0;
      lvl_q      <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      pin_q      <= pin_d;
      data_q     <= data_d;
      lvl_q      <= lvl_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    pin_d      = pin_q;
    data_d     = data_q;
    lvl_d      = lvl_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d       = gpio_op_e'(cmd_op);
          pin_d      = cmd_pin;
          data_d     = cmd_data;
          lvl_d      = cmd_data[16];
          cnt_d      = cmd_data[15:0];
          err_d      = 1'b0;
          rsp_data_d = '0;
          case (cmd_op)
            OP_REG_WR: begin
              addr_d  = cmd_addr & ~ADDR_W'(3);
              state_d = ST_WR;
            end
            OP_REG_RD: begin
              addr_d  = cmd_addr & ~ADDR_W'(3);
              state_d = ST_RD;
            end
            OP_PIN_SET, OP_PIN_CLR, OP_PIN_TGL: begin
              addr_d  = ADDR_W'(GPIO_ODR);
              state_d = ST_RD;
            end
            OP_PIN_WAIT: begin
              addr_d  = ADDR_W'(GPIO_IDR);
              state_d = ST_POLL;
            end
            default: begin
              // illegal op: error response without touching the bus
              addr_d  = '0;
              err_d   = 1'b1;
              state_d = ST_RSP;
            end
          endcase
        end
      end
      ST_RD: begin
        if (op_q == OP_REG_RD) begin
          rsp_data_d = rdata;
          state_d    = ST_RSP;
        end else begin
          case (op_q)
            OP_PIN_SET: data_d = rdata | mask;
            OP_PIN_CLR: data_d = rdata & ~mask;
            default:    data_d = rdata ^ mask;
          endcase
          state_d = ST_WR;
        end
      end
      ST_WR: begin
        rsp_data_d = data_q;
        state_d    = ST_RSP;
      end
      ST_POLL: begin
        if (rdata[pin_q] == lvl_q) begin
          rsp_data_d = rdata;
          state_d    = ST_RSP;
        end else if (cnt_q == 16'd0) begin
          rsp_data_d = rdata;
          err_d      = 1'b1;
          state_d    = ST_RSP;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_RSP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus and handshake outputs decode from the state register only.
  assign bus_act   = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_POLL);
  assign ce        = bus_act;
  assign wr_en     = (state_q == ST_WR);
  assign addr      = bus_act ? addr_q : '0;
  assign wdata     = (state_q == ST_WR) ? data_q : '0;
  assign cmd_ready = (state_q == ST_IDLE);
  assign rsp_valid = (state_q == ST_RSP);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_gpio_bus_initiator.sv
// Directed bench for gpio_bus_initiator with a small MODER/IDR/ODR responder model.
module tb_gpio_bus_initiator;
  import gpio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [4:0]  cmd_addr = 5'd0;
  logic [4:0]  cmd_pin = 5'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        ce;
  logic        wr_en;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic [31:0] moder = 32'd0;
  logic [31:0] odr   = 32'd0;
  logic [31:0] idr   = 32'd0;
  int wr_cnt = 0;
  int idr_rd_cnt = 0;
  int ce_cnt = 0;

  int total = 0;
  int bad = 0;

  gpio_bus_initiator #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_pin(cmd_pin), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .ce(ce), .wr_en(wr_en), .addr(addr), .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  always_comb begin
    rdata = 32'd0;
    case (addr)
      5'h00:   rdata = moder;
      5'h04:   rdata = idr;
      5'h08:   rdata = odr;
      default: rdata = 32'd0;
    endcase
  end

  always @(posedge clk) begin
    if (ce) ce_cnt <= ce_cnt + 1;
    if (ce && wr_en) begin
      wr_cnt <= wr_cnt + 1;
      if (addr == 5'h00) moder <= wdata;
      if (addr == 5'h08) odr <= wdata;
    end
    if (ce && !wr_en && addr == 5'h04) idr_rd_cnt <= idr_rd_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly the accept edge; returns in cycle 1.
  task automatic send(input logic [2:0] op, input logic [4:0] a, input logic [4:0] pin,
                      input logic [31:0] d);
    cmd_op = op; cmd_addr = a; cmd_pin = pin; cmd_data = d; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic pin_op(input string tag, input logic [2:0] op, input logic [4:0] pin,
                        input logic [31:0] exp);
    send(op, 5'd0, pin, 32'd0);
    chk({tag, " c1 ce"}, 32'(ce), 32'd1);
    chk({tag, " c1 wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, " c1 addr"}, 32'(addr), 32'h08);
    chk({tag, " c1 ready"}, 32'(cmd_ready), 32'd0);
    tick();
    chk({tag, " c2 wr_en"}, 32'(wr_en), 32'd1);
    chk({tag, " c2 wdata"}, wdata, exp);
    chk({tag, " c2 rsp_valid"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, " c3 rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, " c3 rsp_data"}, rsp_data, exp);
    chk({tag, " c3 rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " c3 ce"}, 32'(ce), 32'd0);
    tick();
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, " rsp_data"}, rsp_data, 32'd0);
    chk({tag, " ce"}, 32'(ce), 32'd0);
    chk({tag, " wr_en"}, 32'(wr_en), 32'd0);
    chk({tag, " addr"}, 32'(addr), 32'd0);
    chk({tag, " wdata"}, wdata, 32'd0);
  endtask

  initial begin
    int wr_snap, ce_snap;

    // reset
    reset = 1'b0;
    tick(); tick();
    chk_reset_outputs("rst");
    reset = 1'b1;
    tick();

    // REG_WR MODER = 0xF
    send(3'd0, 5'h00, 5'd0, 32'h0000000F);
    chk("wr c1 ce", 32'(ce), 32'd1);
    chk("wr c1 wr_en", 32'(wr_en), 32'd1);
    chk("wr c1 addr", 32'(addr), 32'h00);
    chk("wr c1 wdata", wdata, 32'h0F);
    chk("wr c1 rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("wr c2 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr c2 rsp_data", rsp_data, 32'h0F);
    chk("wr c2 rsp_err", 32'(rsp_err), 32'd0);
    chk("wr c2 ready", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr c3 ready", 32'(cmd_ready), 32'd1);
    chk("wr c3 rsp_valid", 32'(rsp_valid), 32'd0);
    chk("moder value", moder, 32'h0F);

    // REG_RD MODER, low address bits ignored
    send(3'd1, 5'h03, 5'd0, 32'd0);
    chk("rd c1 ce", 32'(ce), 32'd1);
    chk("rd c1 wr_en", 32'(wr_en), 32'd0);
    chk("rd c1 addr", 32'(addr), 32'h00);
    tick();
    chk("rd c2 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd c2 rsp_data", rsp_data, 32'h0F);
    tick();

    // preload ODR = 0x5, then pin RMW sequence
    send(3'd0, 5'h08, 5'd0, 32'h5);
    tick(); tick();
    chk("odr preload", odr, 32'h5);
    pin_op("set1", 3'd2, 5'd1, 32'h7);
    pin_op("clr0", 3'd3, 5'd0, 32'h6);
    pin_op("tgl3", 3'd4, 5'd3, 32'hE);
    chk("odr after rmw", odr, 32'hE);

    // PIN_WAIT pin 2 level 1 timeout 10: pin rises for the 5th sample
    idr = 32'd0;
    idr_rd_cnt = 0;
    send(3'd5, 5'd0, 5'd2, 32'h0001_000A);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("wait c%0d ce", i), 32'(ce), 32'd1);
      chk($sformatf("wait c%0d addr", i), 32'(addr), 32'h04);
      tick();
    end
    idr = 32'h4;
    chk("wait c5 ce", 32'(ce), 32'd1);
    chk("wait c5 rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    chk("wait c6 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wait c6 rsp_err", 32'(rsp_err), 32'd0);
    chk("wait c6 rsp_data", rsp_data, 32'h4);
    chk("wait samples", 32'(idr_rd_cnt), 32'd5);
    tick();

    // PIN_WAIT timeout 3, never matches
    idr = 32'd0;
    idr_rd_cnt = 0;
    send(3'd5, 5'd0, 5'd5, 32'h0001_0003);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("tmo c%0d rsp_valid", i), 32'(rsp_valid), 32'd0);
      tick();
    end
    chk("tmo c5 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("tmo c5 rsp_err", 32'(rsp_err), 32'd1);
    chk("tmo c5 rsp_data", rsp_data, 32'd0);
    chk("tmo samples", 32'(idr_rd_cnt), 32'd4);
    tick();

    // illegal op 7
    ce_snap = ce_cnt;
    send(3'd7, 5'd0, 5'd0, 32'hDEAD_BEEF);
    chk("ill c1 rsp_valid", 32'(rsp_valid), 32'd1);
    chk("ill c1 rsp_err", 32'(rsp_err), 32'd1);
    chk("ill c1 rsp_data", rsp_data, 32'd0);
    chk("ill c1 ce", 32'(ce), 32'd0);
    tick();
    chk("ill ready", 32'(cmd_ready), 32'd1);
    chk("ill no bus", 32'(ce_cnt - ce_snap), 32'd0);

    // reset during cycle 1 of PIN_TGL drops the command
    wr_snap = wr_cnt;
    send(3'd4, 5'd0, 5'd0, 32'd0);
    chk("abort c1 ce", 32'(ce), 32'd1);
    reset = 1'b0;
    tick();
    chk_reset_outputs("abort rst");
    tick();
    reset = 1'b1;
    tick();
    chk("abort ready", 32'(cmd_ready), 32'd1);
    chk("abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort ce", 32'(ce), 32'd0);
    chk("abort no write", 32'(wr_cnt - wr_snap), 32'd0);
    chk("abort odr kept", odr, 32'hE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
